add_rs_dispatch: RTL and testbench

Reservation-station front end for one integer add/sub functional unit in the Tomasulo core. Accepts issued instructions with operand values or producer ROB tags and snoops the common data bus (CDB) for missing operands. Dispatches the oldest fully-ready entry to the adder as a one-cycle `fla` pulse carrying `data1`/`data2`/`des`/`fun7`. It is the sending end of the adder's operand interface, and it also consumes the same CDB broadcast the adder produces.

---
 rtl/add_rs_dispatch_if.sv | 40 ++++
 rtl/add_rs_dispatch.sv | 189 ++++++++++++++++++
 tb/tb_add_rs_dispatch.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_rs_dispatch_if.sv
// rtl/add_rs_dispatch_if.sv - issue, CDB snoop and adder dispatch signals of the add/sub reservation station
// master: the reservation station; slave: the issue stage / CDB / adder side.
interface add_rs_dispatch_if #(
  parameter int DW   = 32,
  parameter int TAGW = 3
);
  logic            issue_valid;
  logic            issue_ready;
  logic [6:0]      issue_fun7;
  logic [TAGW-1:0] issue_des;
  logic [DW-1:0]   issue_v1;
  logic [DW-1:0]   issue_v2;
  logic            issue_rdy1;
  logic            issue_rdy2;
  logic [TAGW-1:0] issue_tag1;
  logic [TAGW-1:0] issue_tag2;
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            fu_busy;
  logic            fla;
  logic [DW-1:0]   data1;
  logic [DW-1:0]   data2;
  logic [TAGW-1:0] des;
  logic [6:0]      fun7;

  modport master (
    input  issue_valid, issue_fun7, issue_des, issue_v1, issue_v2,
           issue_rdy1, issue_rdy2, issue_tag1, issue_tag2,
           cdb_valid, cdb_tag, cdb_data, fu_busy,
    output issue_ready, fla, data1, data2, des, fun7
  );

  modport slave (
    output issue_valid, issue_fun7, issue_des, issue_v1, issue_v2,
           issue_rdy1, issue_rdy2, issue_tag1, issue_tag2,
           cdb_valid, cdb_tag, cdb_data, fu_busy,
    input  issue_ready, fla, data1, data2, des, fun7
  );
endinterface

// File: rtl/add_rs_dispatch.sv
// rtl/add_rs_dispatch.sv - reservation station for the add/sub unit: issue, CDB wake-up, oldest-ready dispatch
// Optional ADDRS_ISSUE_BYPASS_EN: issuing operands capture a same-cycle CDB broadcast.
module add_rs_dispatch #(
  parameter int ENTRIES = 3,
  parameter int DW      = 32,
  parameter int TAGW    = 3
) (
  input  logic                         clk1,
  input  logic                         rst,
  add_rs_dispatch_if.master            bus,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);
  localparam int OW = $clog2(ENTRIES + 1);
  localparam int IW = $clog2(ENTRIES);

  logic            valid_q [ENTRIES], valid_d [ENTRIES];
  logic [6:0]      efun7_q [ENTRIES], efun7_d [ENTRIES];
  logic [TAGW-1:0] edes_q  [ENTRIES], edes_d  [ENTRIES];
  logic [DW-1:0]   v1_q    [ENTRIES], v1_d    [ENTRIES];
  logic [DW-1:0]   v2_q    [ENTRIES], v2_d    [ENTRIES];
  logic            rdy1_q  [ENTRIES], rdy1_d  [ENTRIES];
  logic            rdy2_q  [ENTRIES], rdy2_d  [ENTRIES];
  logic [TAGW-1:0] tag1_q  [ENTRIES], tag1_d  [ENTRIES];
  logic [TAGW-1:0] tag2_q  [ENTRIES], tag2_d  [ENTRIES];
  logic [IW-1:0]   rank_q  [ENTRIES], rank_d  [ENTRIES];

  logic            fla_q, fla_d;
  logic [DW-1:0]   data1_q, data1_d, data2_q, data2_d;
  logic [TAGW-1:0] des_q, des_d;
  logic [6:0]      fun7_q, fun7_d;
  logic [OW-1:0]   occ_q, occ_d;

  logic            dsp_go;
  logic [IW-1:0]   dsp_idx;
  logic [IW-1:0]   dsp_rank;
  logic            issue_ready;
  logic            issue_fire;
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic [OW-1:0]   occ_after;
  logic            byp1, byp2;

  // Oldest registered-ready entry wins; ranks are unique among valid entries.
  always_comb begin
    dsp_go   = 1'b0;
    dsp_idx  = '0;
    dsp_rank = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!bus.fu_busy && !fla_q && valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
          (!dsp_go || rank_q[i] < dsp_rank)) begin
        dsp_go   = 1'b1;
        dsp_idx  = IW'(i);
        dsp_rank = rank_q[i];
      end
    end
  end

  always_comb begin
    issue_ready = (occ_q < OW'(ENTRIES)) || dsp_go;
`ifndef ADDRS_ISSUE_BYPASS_EN
    issue_ready = issue_ready && !bus.cdb_valid;
`endif
    issue_fire = bus.issue_valid && issue_ready;
    occ_after  = occ_q - OW'(dsp_go);
    occ_d      = occ_after + OW'(issue_fire);
`ifdef ADDRS_ISSUE_BYPASS_EN
    byp1 = !bus.issue_rdy1 && bus.cdb_valid && (bus.issue_tag1 == bus.cdb_tag);
    byp2 = !bus.issue_rdy2 && bus.cdb_valid && (bus.issue_tag2 == bus.cdb_tag);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!free_found && !(valid_q[i] && !(dsp_go && IW'(i) == dsp_idx))) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    fla_d   = dsp_go;
    data1_d = data1_q;
    data2_d = data2_q;
    des_d   = des_q;
    fun7_d  = fun7_q;
    if (dsp_go) begin
      data1_d = v1_q[dsp_idx];
      data2_d = v2_q[dsp_idx];
      des_d   = edes_q[dsp_idx];
      fun7_d  = efun7_q[dsp_idx];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      efun7_d[i] = efun7_q[i];
      edes_d[i]  = edes_q[i];
      v1_d[i]    = v1_q[i];
      v2_d[i]    = v2_q[i];
      rdy1_d[i]  = rdy1_q[i];
      rdy2_d[i]  = rdy2_q[i];
      tag1_d[i]  = tag1_q[i];
      tag2_d[i]  = tag2_q[i];
      rank_d[i]  = rank_q[i];
      if (valid_q[i] && bus.cdb_valid) begin
        if (!rdy1_q[i] && tag1_q[i] == bus.cdb_tag) begin
          v1_d[i]   = bus.cdb_data;
          rdy1_d[i] = 1'b1;
        end
        if (!rdy2_q[i] && tag2_q[i] == bus.cdb_tag) begin
          v2_d[i]   = bus.cdb_data;
          rdy2_d[i] = 1'b1;
        end
      end
      if (dsp_go && valid_q[i] && rank_q[i] > dsp_rank) begin
        rank_d[i] = rank_q[i] - 1'b1;
      end
      if (dsp_go && IW'(i) == dsp_idx) begin
        valid_d[i] = 1'b0;
      end
      if (issue_fire && IW'(i) == free_idx) begin
        valid_d[i] = 1'b1;
        efun7_d[i] = bus.issue_fun7;
        edes_d[i]  = bus.issue_des;
        v1_d[i]    = byp1 ? bus.cdb_data : bus.issue_v1;
        v2_d[i]    = byp2 ? bus.cdb_data : bus.issue_v2;
        rdy1_d[i]  = bus.issue_rdy1 || byp1;
        rdy2_d[i]  = bus.issue_rdy2 || byp2;
        tag1_d[i]  = bus.issue_tag1;
        tag2_d[i]  = bus.issue_tag2;
        rank_d[i]  = IW'(occ_after);
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        efun7_q[i] <= '0;
        edes_q[i]  <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        rdy1_q[i]  <= 1'b0;
        rdy2_q[i]  <= 1'b0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        rank_q[i]  <= '0;
      end
      fla_q   <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      des_q   <= '0;
      fun7_q  <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        efun7_q[i] <= efun7_d[i];
        edes_q[i]  <= edes_d[i];
        v1_q[i]    <= v1_d[i];
        v2_q[i]    <= v2_d[i];
        rdy1_q[i]  <= rdy1_d[i];
        rdy2_q[i]  <= rdy2_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        rank_q[i]  <= rank_d[i];
      end
      fla_q   <= fla_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      des_q   <= des_d;
      fun7_q  <= fun7_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.fla         = fla_q;
  assign bus.data1       = data1_q;
  assign bus.data2       = data2_q;
  assign bus.des         = des_q;
  assign bus.fun7        = fun7_q;
  assign occupancy       = occ_q;
endmodule

// File: tb/tb_add_rs_dispatch.sv
// tb/tb_add_rs_dispatch.sv - directed scenarios and randomized run of add_rs_dispatch against a queue model
module tb_add_rs_dispatch;
  localparam int E = 3;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] occupancy;
  int         errors = 0;
  int         checks = 0;

  add_rs_dispatch_if #(.DW(32), .TAGW(3)) bus ();

  add_rs_dispatch #(.ENTRIES(E), .DW(32), .TAGW(3)) dut (
    .clk1(clk1), .rst(rst), .bus(bus), .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  // Model: entries kept in age order, oldest at the front.
  typedef struct {
    logic [6:0]  f;
    logic [2:0]  d;
    logic [31:0] a, b;
    bit          ra, rb;
    logic [2:0]  t1, t2;
  } ent_t;
  ent_t        mq[$];
  logic        m_fla;
  logic [31:0] m_d1, m_d2;
  logic [2:0]  m_des;
  logic [6:0]  m_f7;
  logic        exp_ready, obs_ready;

  function automatic int model_sel();
    if (bus.fu_busy || m_fla) return -1;
    foreach (mq[i]) if (mq[i].ra && mq[i].rb) return i;
    return -1;
  endfunction

  function automatic logic model_ready();
    logic r;
    r = (mq.size() < E) || (model_sel() >= 0);
`ifndef ADDRS_ISSUE_BYPASS_EN
    if (bus.cdb_valid) r = 1'b0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fla = 0; m_d1 = 0; m_d2 = 0; m_des = 0; m_f7 = 0;
  endtask

  task automatic model_commit();
    int   sel;
    logic fire;
    ent_t e;
    sel  = model_sel();
    fire = bus.issue_valid && model_ready();
    m_fla = (sel >= 0);
    if (sel >= 0) begin
      m_d1 = mq[sel].a; m_d2 = mq[sel].b; m_des = mq[sel].d; m_f7 = mq[sel].f;
      mq.delete(sel);
    end
    if (bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].ra && mq[i].t1 == bus.cdb_tag) begin mq[i].a = bus.cdb_data; mq[i].ra = 1; end
        if (!mq[i].rb && mq[i].t2 == bus.cdb_tag) begin mq[i].b = bus.cdb_data; mq[i].rb = 1; end
      end
    end
    if (fire) begin
      e.f = bus.issue_fun7; e.d = bus.issue_des;
      e.a = bus.issue_v1; e.b = bus.issue_v2;
      e.ra = bus.issue_rdy1; e.rb = bus.issue_rdy2;
      e.t1 = bus.issue_tag1; e.t2 = bus.issue_tag2;
`ifdef ADDRS_ISSUE_BYPASS_EN
      if (!e.ra && bus.cdb_valid && e.t1 == bus.cdb_tag) begin e.a = bus.cdb_data; e.ra = 1; end
      if (!e.rb && bus.cdb_valid && e.t2 == bus.cdb_tag) begin e.b = bus.cdb_data; e.rb = 1; end
`endif
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk1);
    exp_ready = model_ready();
    obs_ready = bus.issue_ready;
    model_commit();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive_issue(input logic vld, input logic [6:0] f, input logic [2:0] d,
                             input logic [31:0] v1, input logic r1, input logic [2:0] t1,
                             input logic [31:0] v2, input logic r2, input logic [2:0] t2);
    bus.issue_valid = vld; bus.issue_fun7 = f; bus.issue_des = d;
    bus.issue_v1 = v1; bus.issue_rdy1 = r1; bus.issue_tag1 = t1;
    bus.issue_v2 = v2; bus.issue_rdy2 = r2; bus.issue_tag2 = t2;
  endtask

  task automatic drive_cdb(input logic vld, input logic [2:0] t, input logic [31:0] d);
    bus.cdb_valid = vld; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    bus.fu_busy = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL reset_fla got=%0b want=0", bus.fla); end
    checks++; if (bus.data1 !== 32'd0 || bus.data2 !== 32'd0) begin errors++; $display("FAIL reset_data got=%h/%h want=0/0", bus.data1, bus.data2); end
    checks++; if (bus.des !== 3'd0 || bus.fun7 !== 7'd0) begin errors++; $display("FAIL reset_des_fun7 got=%0d/%b want=0/0", bus.des, bus.fun7); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", bus.issue_ready); end
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    drive_issue(1, 7'b0000000, 3'd2, 32'd5, 1, 0, 32'd7, 1, 0);
    tick();
    checks++; if (bus.fla !== 1'b0 || occupancy !== 2'd1) begin errors++; $display("FAIL add_issue fla/occ got=%0b/%0d want=0/1", bus.fla, occupancy); end
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (bus.fla !== 1'b1) begin errors++; $display("FAIL add_fla got=%0b want=1", bus.fla); end
    checks++; if (bus.data1 !== 32'd5 || bus.data2 !== 32'd7) begin errors++; $display("FAIL add_data got=%0d/%0d want=5/7", bus.data1, bus.data2); end
    checks++; if (bus.des !== 3'd2 || bus.fun7 !== 7'd0) begin errors++; $display("FAIL add_des_fun7 got=%0d/%b want=2/0", bus.des, bus.fun7); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL add_occ got=%0d want=0", occupancy); end
    tick();
    checks++; if (bus.fla !== 1'b0 || bus.data1 !== 32'd5) begin errors++; $display("FAIL add_hold fla/data1 got=%0b/%0d want=0/5", bus.fla, bus.data1); end
  endtask

  task automatic test_cdb_wakeup();
    drive_issue(1, 7'b0100000, 3'd1, 32'd0, 0, 3'd4, 32'd3, 1, 0);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checks++; if (bus.fla !== 1'b0 || occupancy !== 2'd1) begin errors++; $display("FAIL wake_wait fla/occ got=%0b/%0d want=0/1", bus.fla, occupancy); end
    drive_cdb(1, 3'd4, 32'd10);
    tick();
    checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL wake_early got=%0b want=0", bus.fla); end
    drive_cdb(0, 0, 0);
    tick();
    checks++; if (bus.fla !== 1'b1) begin errors++; $display("FAIL wake_fla got=%0b want=1", bus.fla); end
    checks++; if (bus.data1 !== 32'd10 || bus.data2 !== 32'd3) begin errors++; $display("FAIL wake_data got=%0d/%0d want=10/3", bus.data1, bus.data2); end
    checks++; if (bus.fun7 !== 7'b0100000 || bus.des !== 3'd1) begin errors++; $display("FAIL wake_fun7_des got=%b/%0d want=0100000/1", bus.fun7, bus.des); end
    tick();
  endtask

  task automatic test_age_order();
    bus.fu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive_issue(1, 7'd0, 3'(i), 32'd0, 0, 3'(i + 1), 32'(100 + i), 1, 0);
      tick();
    end
    drive_issue(1, 7'd0, 3'd7, 32'd1, 1, 0, 32'd1, 1, 0);
    tick();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b want=0", obs_ready); end
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL full_occ got=%0d want=3", occupancy); end
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(1, 3'd3, 32'd22); tick();
    drive_cdb(1, 3'd1, 32'd20); tick();
    drive_cdb(1, 3'd2, 32'd21); tick();
    drive_cdb(0, 0, 0);
    checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL busy_hold got=%0b want=0", bus.fla); end
    bus.fu_busy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.fla !== 1'b1 || bus.des !== 3'(k) || bus.data1 !== 32'(20 + k)) begin
        errors++; $display("FAIL age_disp%0d fla/des/data1 got=%0b/%0d/%0d want=1/%0d/%0d", k, bus.fla, bus.des, bus.data1, k, 20 + k);
      end
      tick();
      checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL age_gap%0d got=%0b want=0", k, bus.fla); end
    end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL age_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_shared_tag();
    drive_issue(1, 7'd0, 3'd4, 32'd0, 0, 3'd6, 32'd1, 1, 0); tick();
    drive_issue(1, 7'd0, 3'd5, 32'd2, 1, 0, 32'd0, 0, 3'd6); tick();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(1, 3'd6, 32'h66); tick();
    drive_cdb(0, 0, 0);
    checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL shared_early got=%0b want=0", bus.fla); end
    tick();
    checks++; if (bus.fla !== 1'b1 || bus.des !== 3'd4 || bus.data1 !== 32'h66 || bus.data2 !== 32'd1) begin
      errors++; $display("FAIL shared_first fla/des/d1/d2 got=%0b/%0d/%h/%h want=1/4/66/1", bus.fla, bus.des, bus.data1, bus.data2);
    end
    tick();
    tick();
    checks++; if (bus.fla !== 1'b1 || bus.des !== 3'd5 || bus.data1 !== 32'd2 || bus.data2 !== 32'h66) begin
      errors++; $display("FAIL shared_second fla/des/d1/d2 got=%0b/%0d/%h/%h want=1/5/2/66", bus.fla, bus.des, bus.data1, bus.data2);
    end
    tick();
  endtask

  task automatic test_issue_bypass();
    drive_issue(1, 7'd0, 3'd3, 32'd0, 0, 3'd1, 32'd9, 1, 0);
    drive_cdb(1, 3'd1, 32'hFFFF_FFFF);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
`ifdef ADDRS_ISSUE_BYPASS_EN
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got=%0b want=1", obs_ready); end
    tick();
    checks++; if (bus.fla !== 1'b1 || bus.data1 !== 32'hFFFF_FFFF || bus.data2 !== 32'd9) begin
      errors++; $display("FAIL bypass_data fla/d1/d2 got=%0b/%h/%h want=1/ffffffff/9", bus.fla, bus.data1, bus.data2);
    end
`else
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL nobypass_ready got=%0b want=0", obs_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL nobypass_occ got=%0d want=0", occupancy); end
`endif
    tick();
  endtask

  task automatic test_reset_in_flight();
    bus.fu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive_issue(1, 7'd0, 3'(i + 1), 32'(i), 1, 0, 32'(i), 1, 0);
      tick();
    end
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.fu_busy = 0;
    tick();
    checks++; if (bus.fla !== 1'b1 || occupancy !== 2'd2) begin errors++; $display("FAIL flight_setup fla/occ got=%0b/%0d want=1/2", bus.fla, occupancy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.fla !== 1'b0) begin errors++; $display("FAIL flight_fla got=%0b want=0", bus.fla); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flight_occ got=%0d want=0", occupancy); end
    model_reset();
    @(posedge clk1);
    #1;
    rst = 1'b0;
    drive_issue(1, 7'd0, 3'd5, 32'd4, 1, 0, 32'd5, 1, 0); tick();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (bus.fla !== 1'b1 || bus.des !== 3'd5 || bus.data1 !== 32'd4 || bus.data2 !== 32'd5) begin
      errors++; $display("FAIL flight_after fla/des/d1/d2 got=%0b/%0d/%0d/%0d want=1/5/4/5", bus.fla, bus.des, bus.data1, bus.data2);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive_issue($urandom_range(0, 1), 7'($urandom), 3'($urandom), $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom), $urandom, 1'($urandom_range(0, 1)), 3'($urandom));
      drive_cdb($urandom_range(0, 2) == 0, 3'($urandom), $urandom);
      bus.fu_busy = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", n, obs_ready, exp_ready); end
      checks++; if (bus.fla !== m_fla) begin errors++; $display("FAIL rnd_fla cyc=%0d got=%0b want=%0b", n, bus.fla, m_fla); end
      checks++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d want=%0d", n, occupancy, mq.size()); end
      checks++; if (bus.data1 !== m_d1 || bus.data2 !== m_d2 || bus.des !== m_des || bus.fun7 !== m_f7) begin
        errors++; $display("FAIL rnd_out cyc=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", n,
                           bus.data1, bus.data2, bus.des, bus.fun7, m_d1, m_d2, m_des, m_f7);
      end
    end
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    bus.fu_busy = 0;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_cdb_wakeup();
    test_age_order();
    test_shared_tag();
    test_issue_bypass();
    test_reset_in_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
